priority_bus_demux: RTL
=======================

# priority_bus_demux

Receive side of the prioritised 4-requester byte bus. It takes each granted transfer (channel select plus data, with a valid/ready handshake) from the bus multiplexer and steers it into one of four per-channel FIFOs. It drains each FIFO to its destination through an independent valid/ready port. For every accepted transfer it returns a one-cycle acknowledge pulse to the originating requester, which closes the request/grant loop.

## Interface
- DATA_W, 8, width of bus data and of each channel output
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  bus transfer present
- in_sel  input  2  destination channel (0..3) of the current transfer
- in_data  input  DATA_W  bus payload
- in_ready  output  1  selected channel can accept
- ack  output  4  one-hot acknowledge pulse per channel
- out_valid  output  4  channel i FIFO non-empty
- out_ready  input  4  channel i consumer accepts
- out_data0..out_data3  output  DATA_W  head entry of channel i FIFO

## Operation
- Per channel state:
  - storage array of DEPTH × DATA_W
  - write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH
  - count, log2(DEPTH)+1 bits, range 0..DEPTH
- in_ready = (count[in_sel] != DEPTH). This is combinational from in_sel and registered counts. It does not depend on in_valid or out_ready.
- Push: when in_valid && in_ready at a clock edge, write in_data to mem[in_sel][wptr], advance wptr, and increment count. Only channel in_sel is touched.
- Pop: for each channel i, when out_valid[i] && out_ready[i] at a clock edge, advance rptr and decrement count. All four channels may pop in the same cycle.
- Simultaneous push and pop on the same channel: count is unchanged and both pointers advance.
  - A full channel refuses the push even if it pops in the same cycle. No pass-through.
- out_valid[i] = (count[i] != 0). out_data_i = mem[i][rptr[i]].
  - When empty, out_data_i holds the stale entry. Consumers must not use it.
- ack: registered. ack[k] = 1 for exactly one cycle after a push to channel k, and ack is all-zero otherwise.
  - Back-to-back pushes to the same channel give consecutive ack pulses.
  - At most one ack bit is set in any cycle.
- in_valid with in_ready low: no state change, no ack. The sender must hold in_sel and in_data stable until accepted.
- out_ready asserted on an empty channel is ignored.
- No overflow or underflow is possible. The count never leaves 0..DEPTH.

## Timing
- Reset (asynchronous assert, released synchronously by the system):
  - all counts, pointers and storage are 0
  - out_valid = 4'b0000, out_data0..3 = 0, ack = 4'b0000
  - in_ready = 1
- Reset asserted mid-operation: all buffered entries are discarded immediately and outputs return to reset values in the same cycle. Any ack pulse in flight is cleared.
- Latency, input to output: data accepted at edge N is visible on out_data and out_valid after edge N when the channel was empty. Latency is 1 cycle.
- Latency, input to ack: ack is high during the cycle following acceptance edge N, and low after edge N+1.
- Throughput: one push per cycle across all channels, one pop per cycle per channel.
- in_ready reflects the post-edge counts. After a push fills a channel, in_ready for that in_sel is low starting in the next cycle.

## Test plan
- Reset check: assert rst mid-stream with channel 2 holding 2 entries -> out_valid=0000, ack=0000, in_ready=1 immediately; after release, out_valid[2] stays 0.
- Single transfer: push in_sel=1, in_data=8'hA5 -> next cycle ack=0010, out_valid=0010, out_data1=A5; pop with out_ready[1]=1 -> out_valid[1]=0 after the edge.
- Fill and backpressure, DEPTH=2, out_ready=0000:
  - push 8'h11, 8'h22 to channel 3 -> in_ready=0 for in_sel=3, in_ready=1 for in_sel=0
  - third push 8'h33 held -> no ack, data not stored
  - pop once -> 8'h33 accepted the following cycle, ack=1000
  - drain order is 22, 33
- Simultaneous push and pop on channel 0 at count=1: count stays 1, entries drain in FIFO order.
- Wrap-around: 6 pushes and pops through channel 2 with values 01..06 -> output order 01..06 and pointers wrap without loss.
- Full refuses push despite pop: channel 0 full, out_ready[0]=1 and in_valid to channel 0 in the same cycle -> in_ready=0, no ack, count goes to DEPTH-1.
- Parallel drain: channels 0..3 each hold one entry, out_ready=1111 -> all out_valid clear after a single edge.

Source files
------------

// File: rtl/priority_bus_demux.sv
// Receive side of the prioritised 4-requester byte bus: steers granted transfers
// into four per-channel FIFOs, drains each independently, and acknowledges every push.
module priority_bus_demux #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [3:0]        ack,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_W-1:0] mem  [4][DEPTH];
  logic [PW-1:0]     wptr [4];
  logic [PW-1:0]     rptr [4];
  logic [CW-1:0]     cnt  [4];

  logic       push;
  logic [3:0] wr;
  logic [3:0] pop;

  // A full channel refuses the push even if it drains this cycle: no pass-through.
  always_comb begin
    in_ready  = (cnt[in_sel] != FULL);
    push      = in_valid && in_ready;
    wr        = push ? (4'b0001 << in_sel) : 4'b0000;
    out_valid = '0;
    pop       = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      out_valid[i] = (cnt[i] != '0);
      pop[i]       = out_valid[i] && out_ready[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
          mem[i][j] <= '0;
        end
      end
    end else begin
      ack <= wr;
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr[i]) begin
          mem[i][wptr[i]] <= in_data;
          wptr[i]         <= wptr[i] + PW'(1);
        end
        if (pop[i]) begin
          rptr[i] <= rptr[i] + PW'(1);
        end
        case ({wr[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  assign out_data0 = mem[0][rptr[0]];
  assign out_data1 = mem[1][rptr[1]];
  assign out_data2 = mem[2][rptr[2]];
  assign out_data3 = mem[3][rptr[3]];

endmodule
